// File: rtl/table_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : table_sequencer_if
//  Purpose  : Job, pass-handshake and table-reader signals between the
//             dispatch control FSM, the table sequencer and the table reader.
//  Revision : 1.0 - initial release
// ============================================================================
interface table_sequencer_if;
  // Job descriptor handshake
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_passes;
  logic        job_reset;
  // Control from dispatch
  logic        abort_req;
  logic        pass_ready;
  // Table reader link
  logic        table_idle;
  logic [1:0]  table_cmd;
  // Status back to dispatch
  logic        pass_start;
  logic        pass_done;
  logic [15:0] pass_count;
  logic        busy;
  logic        done;
  logic        done_aborted;
  logic        done_error;

  // Sequencer side
  modport slave (
    input  job_valid, job_passes, job_reset, abort_req, pass_ready, table_idle,
    output job_ready, table_cmd, pass_start, pass_done, pass_count, busy,
           done, done_aborted, done_error
  );

  // Dispatch / reader side
  modport master (
    output job_valid, job_passes, job_reset, abort_req, pass_ready, table_idle,
    input  job_ready, table_cmd, pass_start, pass_done, pass_count, busy,
           done, done_aborted, done_error
  );
endinterface
`default_nettype wire

// File: rtl/table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : table_sequencer
//  Purpose  : Runs a multi-pass job on the streaming table reader: optional
//             pointer rewind, one START per pass, idle tracking to delimit
//             passes, abort and start-timeout handling, completion reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module table_sequencer #(
  parameter int n_words       = 40,
  parameter int start_timeout = 4
) (
  input  logic              clk,
  input  logic              ctrl_reset,
  table_sequencer_if.slave  bus
);

  // Reader words per pass and the start-timeout window must leave room for
  // the reader's two-cycle START-to-busy latency.
  generate
    if (n_words < 2 || start_timeout < 3) begin : g_param_check
      $error("table_sequencer: requires n_words >= 2 and start_timeout >= 3");
    end
  endgenerate

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RESET   = 3'd1;
  localparam logic [2:0] S_WAITRDY = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAITLO  = 3'd4;
  localparam logic [2:0] S_STREAM  = 3'd5;
  localparam logic [2:0] S_ABORT   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam int         TW        = $clog2(start_timeout + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(start_timeout);

  logic [2:0]    state_q,       state_d;
  logic [15:0]   passes_left_q, passes_left_d;
  logic [15:0]   pass_count_q,  pass_count_d;
  logic          abort_q,       abort_d;
  logic          err_q,         err_d;
  logic [TW-1:0] to_cnt_q,      to_cnt_d;

  // Abort seen this cycle or earlier in the job.
  logic abort_any;
  assign abort_any = abort_q | bus.abort_req;

  // Next-state and job bookkeeping.
  always_comb begin
    state_d       = state_q;
    passes_left_d = passes_left_q;
    pass_count_d  = pass_count_q;
    abort_d       = abort_q;
    err_d         = err_q;
    to_cnt_d      = to_cnt_q;

    // Abort requests are only meaningful once a job is running.
    if (state_q != S_IDLE && bus.abort_req) begin
      abort_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.job_valid) begin
          passes_left_d = bus.job_passes;
          pass_count_d  = '0;
          abort_d       = 1'b0;
          err_d         = 1'b0;
          // Skip the WAITRDY cycle when the first pass could start at once,
          // so the first START lands one cycle after accept.
          if (bus.job_reset) begin
            state_d = S_RESET;
          end else if (bus.job_passes != 16'd0 && bus.pass_ready) begin
            state_d = S_START;
          end else begin
            state_d = S_WAITRDY;
          end
        end
      end

      S_RESET: begin
        if (passes_left_q == 16'd0 || abort_q) begin
          state_d = S_DONE;
        end else if (bus.pass_ready) begin
          state_d = S_START;
        end else begin
          state_d = S_WAITRDY;
        end
      end

      S_WAITRDY: begin
        if (passes_left_q == 16'd0 || abort_q) begin
          state_d = S_DONE;
        end else if (bus.pass_ready) begin
          state_d = S_START;
        end
      end

      S_START: begin
        to_cnt_d = '0;
        state_d  = S_WAITLO;
      end

      S_WAITLO: begin
        if (!bus.table_idle) begin
          state_d = abort_q ? S_ABORT : S_STREAM;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
          if (to_cnt_q + TW'(1) == TO_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_STREAM: begin
        // Abort takes priority over a pass finishing in the same cycle.
        if (abort_any) begin
          state_d = S_ABORT;
        end else if (bus.table_idle) begin
          if (pass_count_q != 16'hFFFF) begin
            pass_count_d = pass_count_q + 16'd1;
          end
          if (passes_left_q != 16'd0) begin
            passes_left_d = passes_left_q - 16'd1;
          end
          state_d = S_WAITRDY;
        end
      end

      S_ABORT: begin
        if (bus.table_idle) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and job registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (ctrl_reset) begin
      state_q       <= S_IDLE;
      passes_left_q <= '0;
      pass_count_q  <= '0;
      abort_q       <= 1'b0;
      err_q         <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      passes_left_q <= passes_left_d;
      pass_count_q  <= pass_count_d;
      abort_q       <= abort_d;
      err_q         <= err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  // Reader command is a pure decode of the state register.
  always_comb begin
    case (state_q)
      S_RESET: bus.table_cmd = CMD_RESET;
      S_START: bus.table_cmd = CMD_START;
      S_ABORT: bus.table_cmd = CMD_ABORT;
      default: bus.table_cmd = CMD_NONE;
    endcase
  end

  assign bus.job_ready    = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.pass_start   = (state_q == S_START);
  assign bus.pass_done    = (state_q == S_STREAM) && bus.table_idle && !abort_any;
  assign bus.pass_count   = pass_count_q;
  assign bus.done         = (state_q == S_DONE);
  assign bus.done_aborted = (state_q == S_DONE) && abort_q;
  assign bus.done_error   = (state_q == S_DONE) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_table_sequencer
//  Purpose  : Self-checking bench for table_sequencer with a behavioural
//             table-reader model and table-driven job vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_table_sequencer;
  localparam int N_WORDS       = 40;
  localparam int START_TIMEOUT = 4;

  logic clk = 1'b0;
  logic ctrl_reset = 1'b1;

  table_sequencer_if bus();

  table_sequencer #(
    .n_words       (N_WORDS),
    .start_timeout (START_TIMEOUT)
  ) dut (
    .clk        (clk),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reader model: START at k -> idle low from k+2 until idle returns at
  // k+N_WORDS+1; ABORT forces idle high on the following cycle.
  logic rd_idle = 1'b1;
  int   rd_pend = 0;
  int   rd_left = 0;
  logic stuck   = 1'b0;
  always @(posedge clk) begin
    if (ctrl_reset) begin
      rd_idle <= 1'b1; rd_pend <= 0; rd_left <= 0;
    end else if (bus.table_cmd == 2'b11) begin
      rd_idle <= 1'b1; rd_pend <= 0; rd_left <= 0;
    end else if (rd_pend != 0) begin
      rd_pend <= 0; rd_idle <= 1'b0; rd_left <= N_WORDS - 1;
    end else if (!rd_idle) begin
      if (rd_left <= 1) rd_idle <= 1'b1;
      else rd_left <= rd_left - 1;
    end else if (bus.table_cmd == 2'b01 && !stuck) begin
      rd_pend <= 1;
    end
  end
  assign bus.table_idle = rd_idle;

  // Event monitor, sampled on the falling edge.
  int clr_req = 0, clr_seen = 0;
  int m_first_start = -1, m_last_start = -1, m_n_start = 0, m_n_pstart = 0;
  int m_n_reset = 0, m_n_abort = 0, m_n_cmd = 0, m_n_pd = 0, m_cmd_after = 0;
  int m_done_cyc = -1, m_done_cnt = 0, m_done_ab = 0, m_done_err = 0;
  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      m_first_start = -1; m_last_start = -1; m_n_start = 0; m_n_pstart = 0;
      m_n_reset = 0; m_n_abort = 0; m_n_cmd = 0; m_n_pd = 0; m_cmd_after = 0;
      m_done_cyc = -1; m_done_cnt = 0; m_done_ab = 0; m_done_err = 0;
    end else begin
      if (bus.table_cmd != 2'b00) begin
        m_n_cmd++;
        if (m_done_cyc >= 0) m_cmd_after++;
      end
      case (bus.table_cmd)
        2'b01: begin
          if (m_first_start < 0) m_first_start = cyc;
          m_last_start = cyc;
          m_n_start++;
        end
        2'b10: m_n_reset++;
        2'b11: m_n_abort++;
        default: ;
      endcase
      if (bus.pass_start) m_n_pstart++;
      if (bus.pass_done) m_n_pd++;
      if (bus.done && m_done_cyc < 0) begin
        m_done_cyc = cyc;
        m_done_cnt = int'(bus.pass_count);
        m_done_ab  = int'(bus.done_aborted);
        m_done_err = int'(bus.done_error);
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  function automatic int rel(input int x, input int a);
    return (x < 0) ? -1 : x - a;
  endfunction

  task automatic start_job(input int p, input int r, output int a);
    clr_req++;
    bus.job_passes = 16'(p);
    bus.job_reset  = r[0];
    bus.job_valid  = 1'b1;
    a = cyc;
    tick();
    bus.job_valid  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int k = 0;
    while (m_done_cyc < 0 && k < limit) begin
      tick();
      k++;
    end
    chk({name, "_done_seen"}, int'(m_done_cyc >= 0), 1);
  endtask

  typedef struct {
    int passes;
    int jrst;
    int first_start;
    int last_start;
    int n_start;
    int n_reset;
    int done_rel;
    int count;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bus.job_valid  = 1'b0;
    bus.job_passes = 16'd0;
    bus.job_reset  = 1'b0;
    bus.abort_req  = 1'b0;
    bus.pass_ready = 1'b1;

    // passes, reset, first START, last START, #START, #RESET, done, count
    vecs[0] = '{1, 0,  1,  1, 1, 0,  44, 1};
    vecs[1] = '{3, 1,  2, 88, 3, 1, 131, 3};
    vecs[2] = '{0, 1, -1, -1, 0, 1,   2, 0};
    vecs[3] = '{0, 0, -1, -1, 0, 0,   2, 0};
    vecs[4] = '{2, 0,  1, 44, 2, 0,  87, 2};

    ctrl_reset = 1'b1;
    repeat (3) tick();
    ctrl_reset = 1'b0;
    tick();
    chk("rst_job_ready",  int'(bus.job_ready), 1);
    chk("rst_busy",       int'(bus.busy), 0);
    chk("rst_table_cmd",  int'(bus.table_cmd), 0);
    chk("rst_pass_start", int'(bus.pass_start), 0);
    chk("rst_pass_done",  int'(bus.pass_done), 0);
    chk("rst_pass_count", int'(bus.pass_count), 0);
    chk("rst_done",       int'(bus.done), 0);
    chk("rst_done_ab",    int'(bus.done_aborted), 0);
    chk("rst_done_err",   int'(bus.done_error), 0);

    for (int i = 0; i < 5; i++) begin
      start_job(vecs[i].passes, vecs[i].jrst, a);
      wait_done($sformatf("v%0d", i), 400);
      repeat (3) tick();
      chk($sformatf("v%0d_first_start", i), rel(m_first_start, a), vecs[i].first_start);
      chk($sformatf("v%0d_last_start", i),  rel(m_last_start, a),  vecs[i].last_start);
      chk($sformatf("v%0d_n_start", i),     m_n_start,  vecs[i].n_start);
      chk($sformatf("v%0d_n_pstart", i),    m_n_pstart, vecs[i].n_start);
      chk($sformatf("v%0d_n_reset", i),     m_n_reset,  vecs[i].n_reset);
      chk($sformatf("v%0d_n_abort", i),     m_n_abort,  0);
      chk($sformatf("v%0d_done_rel", i),    rel(m_done_cyc, a), vecs[i].done_rel);
      chk($sformatf("v%0d_count", i),       m_done_cnt, vecs[i].count);
      chk($sformatf("v%0d_n_pd", i),        m_n_pd,     vecs[i].count);
      chk($sformatf("v%0d_aborted", i),     m_done_ab,  0);
      chk($sformatf("v%0d_error", i),       m_done_err, 0);
    end

    // pass_ready low for 10 WAITRDY cycles between two passes
    start_job(2, 0, a);
    wait_to(a + 42);
    bus.pass_ready = 1'b0;
    wait_to(a + 53);
    bus.pass_ready = 1'b1;
    wait_done("gap", 400);
    repeat (2) tick();
    chk("gap_second_start", rel(m_last_start, a), 54);
    chk("gap_n_cmd",        m_n_cmd, 2);
    chk("gap_done_rel",     rel(m_done_cyc, a), 97);
    chk("gap_count",        m_done_cnt, 2);

    // abort pulse five cycles into the second pass
    start_job(3, 0, a);
    wait_to(a + 49);
    bus.abort_req = 1'b1;
    tick();
    bus.abort_req = 1'b0;
    wait_done("abort", 400);
    repeat (2) tick();
    chk("abort_n_abort",  m_n_abort, 2);
    chk("abort_done_rel", rel(m_done_cyc, a), 52);
    chk("abort_aborted",  m_done_ab, 1);
    chk("abort_error",    m_done_err, 0);
    chk("abort_count",    m_done_cnt, 1);
    chk("abort_n_start",  m_n_start, 2);

    // abort arriving in the same cycle the reader returns idle
    start_job(2, 0, a);
    wait_to(a + 42);
    bus.abort_req = 1'b1;
    tick();
    bus.abort_req = 1'b0;
    wait_done("tie", 400);
    repeat (2) tick();
    chk("tie_n_pd",     m_n_pd, 0);
    chk("tie_count",    m_done_cnt, 0);
    chk("tie_done_rel", rel(m_done_cyc, a), 44);
    chk("tie_n_abort",  m_n_abort, 1);
    chk("tie_aborted",  m_done_ab, 1);

    // reader never leaves idle: start timeout
    stuck = 1'b1;
    start_job(2, 0, a);
    wait_done("tmo", 100);
    repeat (5) tick();
    stuck = 1'b0;
    chk("tmo_done_rel",  rel(m_done_cyc, a), 6);
    chk("tmo_error",     m_done_err, 1);
    chk("tmo_aborted",   m_done_ab, 0);
    chk("tmo_count",     m_done_cnt, 0);
    chk("tmo_n_start",   m_n_start, 1);
    chk("tmo_cmd_after", m_cmd_after, 0);

    // ctrl_reset in the middle of the second pass
    start_job(2, 0, a);
    wait_to(a + 60);
    chk("crst_pre_count", int'(bus.pass_count), 1);
    chk("crst_pre_busy",  int'(bus.busy), 1);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    @(negedge clk);
    chk("crst_busy",       int'(bus.busy), 0);
    chk("crst_job_ready",  int'(bus.job_ready), 1);
    chk("crst_table_cmd",  int'(bus.table_cmd), 0);
    chk("crst_pass_start", int'(bus.pass_start), 0);
    chk("crst_pass_done",  int'(bus.pass_done), 0);
    chk("crst_pass_count", int'(bus.pass_count), 0);
    chk("crst_done",       int'(bus.done), 0);
    chk("crst_done_ab",    int'(bus.done_aborted), 0);
    chk("crst_done_err",   int'(bus.done_error), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
